// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/exec/writeback sequencer for the reduced RISC-V datapath.
// Owns the PC, instruction register, fetch timeout and retired-instruction counter.
module instr_sequencer #(
    parameter int unsigned            ADDR_WIDTH    = 32,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC      = '0,
    parameter int unsigned            FETCH_TIMEOUT = 15,
    parameter int unsigned            CNT_WIDTH     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run_i,
    output logic                  imem_req_o,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    input  logic                  imem_ack_i,
    input  logic [31:0]           imem_rdata_i,
    output logic [31:0]           instr_o,
    input  logic [31:0]           imm_i,
    input  logic                  eq_i,
    output logic                  reg_write_o,
    output logic [ADDR_WIDTH-1:0] pc_o,
    output logic                  busy_o,
    output logic                  halted_o,
    output logic                  fault_o,
    output logic [CNT_WIDTH-1:0]  retired_o
);

    localparam int unsigned      TMO_W      = 8;
    localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(FETCH_TIMEOUT - 1);
    localparam logic [6:0]       OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0]       OPC_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT, S_FAULT
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [31:0]           instr_q, instr_d;
    logic [CNT_WIDTH-1:0]  retired_q, retired_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic                  taken_q, taken_d;
    logic                  req_q, req_d;
    logic                  wr_q, wr_d;
    logic                  busy_q, busy_d;
    logic                  halted_q, halted_d;
    logic                  fault_q, fault_d;

    logic                  is_branch;
    logic [2:0]            funct3;
    logic [ADDR_WIDTH-1:0] target;

    assign is_branch = (instr_q[6:0] == OPC_BRANCH);
    assign funct3    = instr_q[14:12];
    // Next PC: branch target only when a branch was resolved taken in EXEC.
    assign target    = (is_branch && taken_q) ? pc_q + imm_i[ADDR_WIDTH-1:0]
                                              : pc_q + ADDR_WIDTH'(4);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        retired_d = retired_q;
        tmo_d     = tmo_q;
        taken_d   = taken_q;

        unique case (state_q)
            S_IDLE: begin
                if (run_i) begin
                    state_d = S_FETCH;
                    tmo_d   = '0;
                end
            end
            S_FETCH: begin
                if (imem_ack_i) begin
                    instr_d = imem_rdata_i;
                    state_d = S_DECODE;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_FAULT;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_DECODE: begin
                if (instr_q == 32'h0)
                    state_d = S_HALT;
                else if (instr_q[6:0] == OPC_OPIMM || instr_q[6:0] == OPC_BRANCH)
                    state_d = S_EXEC;
                else
                    state_d = S_FAULT;
            end
            S_EXEC: begin
                taken_d = ((funct3 == 3'b000) && eq_i) || ((funct3 == 3'b001) && !eq_i);
                if (is_branch && (funct3[2:1] != 2'b00))
                    state_d = S_FAULT;
                else
                    state_d = S_WB;
            end
            S_WB: begin
                if (target[1:0] != 2'b00) begin
                    state_d = S_FAULT;
                end else begin
                    pc_d      = target;
                    retired_d = retired_q + CNT_WIDTH'(1);
                    tmo_d     = '0;
                    state_d   = run_i ? S_FETCH : S_IDLE;
                end
            end
            default: ;
        endcase

        req_d    = (state_d == S_FETCH);
        wr_d     = (state_d == S_WB) && !is_branch;
        busy_d   = (state_d == S_FETCH) || (state_d == S_DECODE) ||
                   (state_d == S_EXEC)  || (state_d == S_WB);
        halted_d = (state_d == S_HALT);
        fault_d  = (state_d == S_FAULT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            instr_q   <= '0;
            retired_q <= '0;
            tmo_q     <= '0;
            taken_q   <= 1'b0;
            req_q     <= 1'b0;
            wr_q      <= 1'b0;
            busy_q    <= 1'b0;
            halted_q  <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            retired_q <= retired_d;
            tmo_q     <= tmo_d;
            taken_q   <= taken_d;
            req_q     <= req_d;
            wr_q      <= wr_d;
            busy_q    <= busy_d;
            halted_q  <= halted_d;
            fault_q   <= fault_d;
        end
    end

    assign imem_req_o  = req_q;
    assign imem_addr_o = pc_q;
    assign instr_o     = instr_q;
    assign reg_write_o = wr_q;
    assign pc_o        = pc_q;
    assign busy_o      = busy_q;
    assign halted_o    = halted_q;
    assign fault_o     = fault_q;
    assign retired_o   = retired_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed scenarios plus random programs
// checked against an instruction-level reference model.
module tb_instr_sequencer;

    localparam int TMO = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run_i = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic [31:0] instr_o;
    logic [31:0] imm_i;
    logic        eq_i;
    logic        reg_write_o;
    logic [31:0] pc_o;
    logic        busy_o, halted_o, fault_o;
    logic [15:0] retired_o;

    int total = 0;
    int bad = 0;

    logic [31:0] mem [64];
    int          ack_delay = 0;
    int          cur_delay = 0;
    int          wcnt = 0;
    bit          resp_busy = 0;
    bit          eq_val = 0;
    int          fetch_cnt = 0;
    int          wr_cnt = 0;

    instr_sequencer dut (
        .clk(clk), .rst_n(rst_n), .run_i(run_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_ack_i(imem_ack_i), .imem_rdata_i(imem_rdata_i),
        .instr_o(instr_o), .imm_i(imm_i), .eq_i(eq_i),
        .reg_write_o(reg_write_o), .pc_o(pc_o), .busy_o(busy_o),
        .halted_o(halted_o), .fault_o(fault_o), .retired_o(retired_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc_addi(logic [4:0] rd, logic [11:0] imm);
        return {imm, 5'd0, 3'b000, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_br(logic [2:0] f3, logic [12:0] imm);
        return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    // Stands in for the decoder's immediate generator.
    function automatic logic [31:0] dec_imm(logic [31:0] ins);
        if (ins[6:0] == 7'b0010011) return {{20{ins[31]}}, ins[31:20]};
        if (ins[6:0] == 7'b1100011)
            return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        return '0;
    endfunction

    assign imm_i = dec_imm(instr_o);
    assign eq_i  = eq_val;

    always @(posedge imem_req_o) fetch_cnt++;
    always @(posedge reg_write_o) wr_cnt++;

    // Instruction memory: acks after a per-fetch delay latched at the first FETCH cycle.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_ack_i = 1'b0;
            resp_busy  = 0;
        end else if (imem_ack_i) begin
            imem_ack_i = 1'b0;
        end else if (imem_req_o) begin
            if (!resp_busy) begin
                resp_busy = 1;
                cur_delay = ack_delay;
                wcnt      = 0;
            end
            if (wcnt >= cur_delay) begin
                imem_ack_i   = 1'b1;
                imem_rdata_i = mem[imem_addr_o[7:2]];
                resp_busy    = 0;
            end else begin
                wcnt++;
            end
        end else begin
            resp_busy = 0;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        run_i = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic fill_addi();
        for (int i = 0; i < 64; i++) mem[i] = enc_addi(5'd1, 12'd5);
    endtask

    task automatic wait_fetch(output bit ok, output logic [31:0] a);
        int start;
        start = fetch_cnt;
        ok = 0;
        a = '0;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (fetch_cnt != start) begin
                ok = 1;
                a  = imem_addr_o;
                return;
            end
        end
        total++; bad++;
        $display("FAIL fetch_wait: no imem_req within 64 cycles (fetches=%0d)", fetch_cnt);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        total++;
        if ({imem_req_o, reg_write_o, busy_o, halted_o, fault_o} !== 5'b0) begin
            bad++; $display("FAIL reset_flags: got %b want 00000",
                            {imem_req_o, reg_write_o, busy_o, halted_o, fault_o});
        end
        total++;
        if (pc_o !== 32'h0 || instr_o !== 32'h0 || retired_o !== 16'h0) begin
            bad++; $display("FAIL reset_regs: pc=%h instr=%h ret=%0d want 0/0/0", pc_o, instr_o, retired_o);
        end
        do_reset();
        tick();
        total++;
        if (busy_o !== 1'b0 || imem_req_o !== 1'b0) begin
            bad++; $display("FAIL idle_no_run: busy=%b req=%b want 0/0", busy_o, imem_req_o);
        end
    endtask

    task automatic test_addi();
        bit ok; logic [31:0] a; logic [3:0] wr;
        fill_addi();
        mem[0] = 32'h00500093;
        ack_delay = 0;
        do_reset();
        run_i = 1'b1;
        wait_fetch(ok, a);
        wr[0] = reg_write_o;
        tick(); wr[1] = reg_write_o;
        tick(); wr[2] = reg_write_o;
        tick(); wr[3] = reg_write_o;
        total++;
        if (wr !== 4'b1000) begin
            bad++; $display("FAIL addi_wr_cycle: reg_write per cycle 1..4 = %b want 1000 (msb=cycle4)", wr);
        end
        tick();
        total++;
        if (pc_o !== 32'h4 || retired_o !== 16'd1 || reg_write_o !== 1'b0) begin
            bad++; $display("FAIL addi_retire: pc=%h ret=%0d wr=%b want 4/1/0", pc_o, retired_o, reg_write_o);
        end
        total++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h4) begin
            bad++; $display("FAIL addi_next_fetch: req=%b addr=%h want 1/4", imem_req_o, imem_addr_o);
        end
    endtask

    task automatic test_bne();
        bit ok; logic [31:0] a; int w0;
        fill_addi();
        mem[4] = enc_br(3'b001, 13'h1FF8);
        ack_delay = 0;
        eq_val = 0;
        do_reset();
        w0 = wr_cnt;
        run_i = 1'b1;
        for (int i = 0; i < 5; i++) wait_fetch(ok, a);
        total++;
        if (a !== 32'h10) begin
            bad++; $display("FAIL bne_reach: addr=%h want 10", a);
        end
        wait_fetch(ok, a);
        total++;
        if (a !== 32'h08) begin
            bad++; $display("FAIL bne_taken: addr=%h want 08", a);
        end
        eq_val = 1;
        wait_fetch(ok, a);
        wait_fetch(ok, a);
        wait_fetch(ok, a);
        total++;
        if (a !== 32'h14) begin
            bad++; $display("FAIL bne_not_taken: addr=%h want 14", a);
        end
        total++;
        if (retired_o !== 16'd8 || (wr_cnt - w0) != 6) begin
            bad++; $display("FAIL bne_counts: ret=%0d writes=%0d want 8/6", retired_o, wr_cnt - w0);
        end
    endtask

    task automatic test_timeout();
        bit ok; logic [31:0] a; int fc;
        fill_addi();
        ack_delay = TMO;
        do_reset();
        run_i = 1'b1;
        wait_fetch(ok, a);
        for (int k = 2; k <= TMO; k++) tick();
        total++;
        if (imem_req_o !== 1'b1 || fault_o !== 1'b0) begin
            bad++; $display("FAIL tmo_last_cycle: req=%b fault=%b want 1/0", imem_req_o, fault_o);
        end
        tick();
        total++;
        if (fault_o !== 1'b1 || imem_req_o !== 1'b0 || pc_o !== 32'h0) begin
            bad++; $display("FAIL tmo_fault: fault=%b req=%b pc=%h want 1/0/0", fault_o, imem_req_o, pc_o);
        end
        fc = fetch_cnt;
        for (int k = 0; k < 5; k++) tick();
        total++;
        if (fault_o !== 1'b1 || fetch_cnt != fc || busy_o !== 1'b0) begin
            bad++; $display("FAIL tmo_sticky: fault=%b fetches=%0d busy=%b want 1/%0d/0", fault_o, fetch_cnt, busy_o, fc);
        end
        ack_delay = TMO - 1;
        do_reset();
        run_i = 1'b1;
        wait_fetch(ok, a);
        wait_fetch(ok, a);
        total++;
        if (!ok || a !== 32'h4 || fault_o !== 1'b0 || retired_o !== 16'd1) begin
            bad++; $display("FAIL tmo_ack_last: addr=%h fault=%b ret=%0d want 4/0/1", a, fault_o, retired_o);
        end
    endtask

    task automatic test_halt();
        bit ok; logic [31:0] a; int fc;
        fill_addi();
        mem[0] = 32'h0;
        ack_delay = 0;
        do_reset();
        run_i = 1'b1;
        wait_fetch(ok, a);
        fc = fetch_cnt;
        for (int k = 0; k < 8; k++) tick();
        total++;
        if (halted_o !== 1'b1 || fault_o !== 1'b0 || busy_o !== 1'b0) begin
            bad++; $display("FAIL halt_flags: halted=%b fault=%b busy=%b want 1/0/0", halted_o, fault_o, busy_o);
        end
        total++;
        if (retired_o !== 16'd0 || fetch_cnt != fc || pc_o !== 32'h0 || imem_req_o !== 1'b0) begin
            bad++; $display("FAIL halt_frozen: ret=%0d fetches=%0d pc=%h req=%b want 0/%0d/0/0",
                            retired_o, fetch_cnt, pc_o, imem_req_o, fc);
        end
    endtask

    task automatic test_run_drop();
        bit ok; logic [31:0] a; int fc;
        fill_addi();
        ack_delay = 0;
        do_reset();
        run_i = 1'b1;
        wait_fetch(ok, a);
        tick();
        tick();
        run_i = 1'b0;
        fc = fetch_cnt;
        for (int k = 0; k < 6; k++) tick();
        total++;
        if (retired_o !== 16'd1 || pc_o !== 32'h4 || busy_o !== 1'b0 ||
            imem_req_o !== 1'b0 || fetch_cnt != fc) begin
            bad++; $display("FAIL run_drop: ret=%0d pc=%h busy=%b req=%b fetches=%0d want 1/4/0/0/%0d",
                            retired_o, pc_o, busy_o, imem_req_o, fetch_cnt, fc);
        end
        run_i = 1'b1;
        wait_fetch(ok, a);
        total++;
        if (a !== 32'h4) begin
            bad++; $display("FAIL run_resume: addr=%h want 4", a);
        end
    endtask

    task automatic test_reset_mid_fetch();
        bit ok; logic [31:0] a;
        fill_addi();
        ack_delay = 0;
        do_reset();
        run_i = 1'b1;
        wait_fetch(ok, a);
        ack_delay = 5;
        wait_fetch(ok, a);
        tick();
        rst_n = 1'b0;
        #1;
        total++;
        if (imem_req_o !== 1'b0 || pc_o !== 32'h0 || retired_o !== 16'd0) begin
            bad++; $display("FAIL reset_mid_fetch: req=%b pc=%h ret=%0d want 0/0/0", imem_req_o, pc_o, retired_o);
        end
        mem[0] = enc_br(3'b000, 13'd2);
        eq_val = 1;
        ack_delay = 0;
        do_reset();
        run_i = 1'b1;
        wait_fetch(ok, a);
        for (int k = 0; k < 6; k++) tick();
        total++;
        if (fault_o !== 1'b1 || pc_o !== 32'h0 || retired_o !== 16'd0) begin
            bad++; $display("FAIL misaligned_target: fault=%b pc=%h ret=%0d want 1/0/0", fault_o, pc_o, retired_o);
        end
    endtask

    function automatic logic [31:0] rand_instr();
        int r, k;
        r = $urandom_range(0, 99);
        if (r < 55) return enc_addi(5'($urandom), 12'($urandom));
        k = $urandom_range(0, 12) - 6;
        if (r < 85) return enc_br({2'b00, 1'($urandom)}, 13'(k * 4));
        if (r < 90) return enc_br({2'b00, 1'($urandom)}, 13'(k * 4 + 2));
        if (r < 94) return enc_br(3'($urandom_range(2, 7)), 13'(k * 4));
        if (r < 97) return {25'($urandom), 7'b0110011};
        return 32'h0;
    endfunction

    function automatic int pick_delay();
        if ($urandom_range(0, 99) < 4) return TMO;
        return $urandom_range(0, 3);
    endfunction

    task automatic test_random();
        bit ok, term, efault, ehalt, taken, eq;
        logic [31:0] a, ins, epc, tgt, imm;
        logic [15:0] eret;
        int ewr, w0, dly, fc;
        for (int trial = 0; trial < 12; trial++) begin
            for (int i = 0; i < 64; i++) mem[i] = rand_instr();
            dly = pick_delay();
            ack_delay = dly;
            do_reset();
            w0 = wr_cnt;
            epc = '0; eret = '0; ewr = 0;
            term = 0; efault = 0; ehalt = 0;
            run_i = 1'b1;
            for (int n = 0; n < 40 && !term; n++) begin
                wait_fetch(ok, a);
                if (!ok) break;
                total++;
                if (a !== epc || retired_o !== eret || (wr_cnt - w0) != ewr) begin
                    bad++; $display("FAIL rand_fetch t%0d n%0d: addr=%h ret=%0d wr=%0d want %h/%0d/%0d",
                                    trial, n, a, retired_o, wr_cnt - w0, epc, eret, ewr);
                end
                eq = 1'($urandom);
                eq_val = eq;
                ins = mem[epc[7:2]];
                if (dly >= TMO) begin
                    term = 1; efault = 1;
                end else if (ins == 32'h0) begin
                    term = 1; ehalt = 1;
                end else if (ins[6:0] == 7'b0010011) begin
                    epc = epc + 32'd4; eret++; ewr++;
                end else if (ins[6:0] == 7'b1100011 && ins[14:13] == 2'b00) begin
                    imm   = dec_imm(ins);
                    taken = ins[12] ? !eq : eq;
                    tgt   = taken ? epc + imm : epc + 32'd4;
                    if (tgt[1:0] != 2'b00) begin
                        term = 1; efault = 1;
                    end else begin
                        epc = tgt; eret++;
                    end
                end else begin
                    term = 1; efault = 1;
                end
                dly = pick_delay();
                ack_delay = dly;
            end
            if (term) begin
                fc = fetch_cnt;
                for (int k = 0; k < TMO + 8; k++) tick();
                total++;
                if (fault_o !== efault || halted_o !== ehalt || pc_o !== epc ||
                    retired_o !== eret || busy_o !== 1'b0 || fetch_cnt != fc) begin
                    bad++; $display("FAIL rand_end t%0d: fault=%b halt=%b pc=%h ret=%0d busy=%b want %b/%b/%h/%0d/0",
                                    trial, fault_o, halted_o, pc_o, retired_o, busy_o, efault, ehalt, epc, eret);
                end
            end
            run_i = 1'b0;
        end
    endtask

    initial begin
        fill_addi();
        test_reset();
        test_addi();
        test_bne();
        test_timeout();
        test_halt();
        test_run_drop();
        test_reset_mid_fetch();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
